// File: rtl/uart_8n1.sv
// uart_8n1: full-duplex 8N1 UART with valid/ready byte ports.
// Bit timing comes from a fixed integer divisor of the system clock.
module uart_8n1 #(
   parameter int CLK_FREQ  = 100000000,
   parameter int BAUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] uart_rd_data,
   output logic       uart_rd_valid,
   input  logic       uart_rd_ready,
   input  logic [7:0] uart_wr_data,
   input  logic       uart_wr_valid,
   output logic       uart_wr_ready,
   input  logic       uart_rxd,
   output logic       uart_txd
);

   localparam int DIV  = CLK_FREQ / BAUD_RATE;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV);

   localparam logic [CW-1:0] DIV_END  = CW'(DIV - 1);
   localparam logic [CW-1:0] STOP_END = CW'(DIV - 2);
   localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_BREAK
   } rx_state_t;

   tx_state_t     tx_state;
   logic [CW-1:0] tx_cnt;
   logic [2:0]    tx_idx;
   logic [7:0]    tx_shift;

   rx_state_t     rx_state;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_idx;
   logic [7:0]    rx_shift;
   logic [1:0]    rx_sync;
   logic          rx_bit;

   assign rx_bit = rx_sync[1];

   // Stop bit ends one clock early so a held wr_valid restarts with no gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state      <= TX_IDLE;
         tx_cnt        <= '0;
         tx_idx        <= '0;
         tx_shift      <= '0;
         uart_txd      <= 1'b1;
         uart_wr_ready <= 1'b0;
      end else begin
         unique case (tx_state)
            TX_IDLE: begin
               if (uart_wr_valid && uart_wr_ready) begin
                  tx_shift      <= uart_wr_data;
                  tx_cnt        <= '0;
                  uart_wr_ready <= 1'b0;
                  uart_txd      <= 1'b0;
                  tx_state      <= TX_START;
               end else begin
                  uart_wr_ready <= 1'b1;
                  uart_txd      <= 1'b1;
               end
            end
            TX_START: begin
               if (tx_cnt == DIV_END) begin
                  tx_cnt   <= '0;
                  tx_idx   <= '0;
                  uart_txd <= tx_shift[0];
                  tx_shift <= tx_shift >> 1;
                  tx_state <= TX_DATA;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            TX_DATA: begin
               if (tx_cnt == DIV_END) begin
                  tx_cnt <= '0;
                  if (tx_idx == 3'd7) begin
                     uart_txd <= 1'b1;
                     tx_state <= TX_STOP;
                  end else begin
                     tx_idx   <= tx_idx + 1'b1;
                     uart_txd <= tx_shift[0];
                     tx_shift <= tx_shift >> 1;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            TX_STOP: begin
               if (tx_cnt == STOP_END) begin
                  tx_cnt        <= '0;
                  uart_wr_ready <= 1'b1;
                  tx_state      <= TX_IDLE;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // A new byte completing while valid overwrites the held one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_sync       <= 2'b11;
         rx_state      <= RX_IDLE;
         rx_cnt        <= '0;
         rx_idx        <= '0;
         rx_shift      <= '0;
         uart_rd_data  <= '0;
         uart_rd_valid <= 1'b0;
      end else begin
         rx_sync <= {rx_sync[0], uart_rxd};
         if (uart_rd_valid && uart_rd_ready)
            uart_rd_valid <= 1'b0;
         unique case (rx_state)
            RX_IDLE: begin
               if (!rx_bit) begin
                  rx_cnt   <= '0;
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (rx_cnt == HALF_END) begin
                  rx_cnt   <= '0;
                  rx_idx   <= '0;
                  rx_state <= rx_bit ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == DIV_END) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_bit, rx_shift[7:1]};
                  if (rx_idx == 3'd7)
                     rx_state <= RX_STOP;
                  else
                     rx_idx <= rx_idx + 1'b1;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == DIV_END) begin
                  rx_cnt <= '0;
                  if (rx_bit) begin
                     uart_rd_data  <= rx_shift;
                     uart_rd_valid <= 1'b1;
                     rx_state      <= RX_IDLE;
                  end else begin
                     rx_state <= RX_BREAK;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_BREAK: begin
               if (rx_bit)
                  rx_state <= RX_IDLE;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_8n1.sv
// tb_uart_8n1: scoreboard bench for uart_8n1 at default baud settings.
// Line monitors pop expected bytes as frames appear on txd and rd_*.
module tb_uart_8n1;

   localparam int CLK_FREQ  = 100000000;
   localparam int BAUD_RATE = 115200;
   localparam int DIV       = CLK_FREQ / BAUD_RATE;
   localparam int HALF      = DIV / 2;
   localparam int FRAME     = 10 * DIV;

   typedef struct packed {
      logic [7:0] b;
      logic       b2b;
   } tx_exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] uart_rd_data;
   logic       uart_rd_valid;
   logic       uart_rd_ready = 1'b0;
   logic [7:0] uart_wr_data = 8'h00;
   logic       uart_wr_valid = 1'b0;
   logic       uart_wr_ready;
   logic       uart_rxd = 1'b1;
   logic       uart_txd;

   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;
   tx_exp_t     txq[$];
   logic [7:0]  rxq[$];

   uart_8n1 #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD_RATE(BAUD_RATE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .uart_rd_data (uart_rd_data),
      .uart_rd_valid(uart_rd_valid),
      .uart_rd_ready(uart_rd_ready),
      .uart_wr_data (uart_wr_data),
      .uart_wr_valid(uart_wr_valid),
      .uart_wr_ready(uart_wr_ready),
      .uart_rxd     (uart_rxd),
      .uart_txd     (uart_txd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!uart_wr_ready && n < 2 * FRAME) begin
         @(negedge clk);
         n++;
      end
      check(name, uart_wr_ready, 1'b1);
   endtask

   // Called at a negedge; returns at the negedge after the handshake edge.
   task automatic tx_offer(input logic [7:0] b);
      uart_wr_data  = b;
      uart_wr_valid = 1'b1;
      wait_ready("tx_offer_ready");
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic tx_drain();
      int n = 0;
      while (txq.size() != 0 && n < 3 * FRAME) begin
         @(negedge clk);
         n++;
      end
      check("tx_drain", txq.size(), 0);
   endtask

   task automatic rx_drain();
      int n = 0;
      while (rxq.size() != 0 && n < 3 * FRAME) begin
         @(negedge clk);
         n++;
      end
      check("rx_drain", rxq.size(), 0);
   endtask

   task automatic rx_frame(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uart_rxd = f[i];
         repeat (DIV) @(negedge clk);
      end
      uart_rxd = 1'b1;
   endtask

   initial begin : tx_mon
      tx_exp_t     e;
      logic [9:0]  frm;
      bit          unstable, aborted, have_last;
      int unsigned t0, last_t0;
      have_last = 0;
      last_t0   = 0;
      forever begin
         @(negedge uart_txd);
         frm      = '0;
         unstable = 0;
         aborted  = 0;
         t0       = 0;
         for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < DIV; k++) begin
               @(negedge clk);
               if (rst) begin
                  aborted = 1;
                  break;
               end
               if (b == 0 && k == 0) t0 = cyc;
               if (k == 0) frm[b] = uart_txd;
               else if (uart_txd !== frm[b]) unstable = 1;
            end
            if (aborted) break;
         end
         if (aborted) begin
            have_last = 0;
            continue;
         end
         if (txq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected_frame: got 0x%0h, none queued", frm);
         end else begin
            e = txq.pop_front();
            check("tx_frame", frm, {1'b1, e.b, 1'b0});
            check("tx_bit_timing", unstable, 1'b0);
            if (e.b2b)
               check("tx_b2b_gap", have_last ? t0 - last_t0 : 0, FRAME);
         end
         last_t0   = t0;
         have_last = 1;
      end
   end

   initial begin : rx_mon
      logic [7:0] held, e;
      bit         pv;
      pv   = 0;
      held = '0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            pv = 0;
            continue;
         end
         if (uart_rd_valid && !pv) begin
            if (rxq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rx_unexpected_byte: got 0x%0h, none queued",
                        uart_rd_data);
            end else begin
               e = rxq.pop_front();
               check("rx_byte", uart_rd_data, e);
            end
            held = uart_rd_data;
         end
         if (uart_rd_valid && uart_rd_ready)
            check("rx_data_stable", uart_rd_data, held);
         pv = uart_rd_valid && !uart_rd_ready;
      end
   end

   initial begin : main
      int n;
      repeat (3) @(negedge clk);
      check("rst_txd", uart_txd, 1'b1);
      check("rst_wr_ready", uart_wr_ready, 1'b0);
      check("rst_rd_valid", uart_rd_valid, 1'b0);
      check("rst_rd_data", uart_rd_data, 8'h00);
      rst = 1'b0;
      @(negedge clk);
      check("wr_ready_after_rst", uart_wr_ready, 1'b1);
      check("txd_idle_after_rst", uart_txd, 1'b1);

      // single byte; data changed after handshake must not matter
      txq.push_back('{b: 8'h48, b2b: 1'b0});
      tx_offer(8'h48);
      uart_wr_valid = 1'b0;
      uart_wr_data  = 8'hFF;
      n = 0;
      while (!uart_wr_ready && n < 2 * FRAME) begin
         n++;
         @(negedge clk);
      end
      check("wr_ready_turnaround", n + 1, FRAME);
      tx_drain();

      // back-to-back with valid held
      repeat (20) @(negedge clk);
      txq.push_back('{b: 8'h48, b2b: 1'b0});
      txq.push_back('{b: 8'h47, b2b: 1'b1});
      tx_offer(8'h48);
      tx_offer(8'h47);
      uart_wr_valid = 1'b0;
      uart_wr_data  = 8'h00;
      wait_ready("wr_ready_after_b2b");
      tx_drain();

      // receive with consumer stalled
      uart_rd_ready = 1'b0;
      rxq.push_back(8'h47);
      rx_frame(8'h47, 1'b1);
      check("rd_valid_up", uart_rd_valid, 1'b1);
      check("rd_data_47", uart_rd_data, 8'h47);
      repeat (50) @(negedge clk);
      check("rd_valid_hold", uart_rd_valid, 1'b1);
      uart_rd_ready = 1'b1;
      @(negedge clk);
      uart_rd_ready = 1'b0;
      check("rd_valid_clear", uart_rd_valid, 1'b0);
      rx_drain();

      // glitch shorter than half a bit
      uart_rxd = 1'b0;
      repeat (200) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (2 * DIV) @(negedge clk);
      check("glitch_no_valid", uart_rd_valid, 1'b0);

      // framing error then a good frame
      rx_frame(8'h5A, 1'b0);
      repeat (2 * DIV) @(negedge clk);
      check("framing_no_valid", uart_rd_valid, 1'b0);
      uart_rd_ready = 1'b1;
      rxq.push_back(8'hA5);
      rx_frame(8'hA5, 1'b1);
      rx_drain();
      uart_rd_ready = 1'b0;
      check("rd_data_a5", uart_rd_data, 8'hA5);

      // reset during data bit 3 of 0xC3 (bit 3 is 0)
      tx_offer(8'hC3);
      uart_wr_valid = 1'b0;
      repeat (4 * DIV + HALF) @(negedge clk);
      check("mid_tx_txd_low", uart_txd, 1'b0);
      rst = 1'b1;
      #1;
      check("mid_rst_txd", uart_txd, 1'b1);
      check("mid_rst_wr_ready", uart_wr_ready, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("wr_ready_after_mid_rst", uart_wr_ready, 1'b1);
      repeat (5) @(negedge clk);
      txq.push_back('{b: 8'h3C, b2b: 1'b0});
      tx_offer(8'h3C);
      uart_wr_valid = 1'b0;
      wait_ready("wr_ready_after_3c");
      tx_drain();
      check("rx_queue_empty", rxq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
